// File: rtl/player_sprite.sv
// Single Atari-style player object: 8-bit graphic with position, height,
// reflect and 1x/2x/4x stretch. Bus writes land in shadow registers and are
// copied to the active set at hpos == 0, so a line in progress never changes.
//
// state | meaning
// IDLE  | waiting for the start pixel of this line
// DRAW  | shifting out graphic bits, one per (PIXEL_UNIT << size) pixels
// DONE  | finished or clipped for this line; waits for hpos == 0
module player_sprite #(
    parameter int PIXEL_UNIT = 4,
    parameter int LINE_START = 88
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_enable,
    input  logic [2:0] address,
    input  logic [7:0] data_in,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       in_image,
    input  logic       is_fg,
    output logic       sprite_on,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       collision
);

    localparam int SUB_W = $clog2(PIXEL_UNIT * 4);
    localparam logic [SUB_W-1:0] LAST_1X = SUB_W'(PIXEL_UNIT - 1);
    localparam logic [SUB_W-1:0] LAST_2X = SUB_W'(2 * PIXEL_UNIT - 1);
    localparam logic [SUB_W-1:0] LAST_4X = SUB_W'(4 * PIXEL_UNIT - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_gfx_sh, r_gfx;
    logic [9:0]       r_x_sh, r_x;
    logic             r_refl_sh, r_refl;
    logic [1:0]       r_size_sh, r_size;
    logic [9:0]       r_y_sh, r_y;
    logic [7:0]       r_h_sh, r_h;
    logic [7:0]       r_col_sh, r_col;
    logic [2:0]       r_bit_idx, w_bit_nxt, w_bit, w_bit_end;
    logic [SUB_W-1:0] r_sub, w_sub_nxt, w_sub, w_sub_last;
    logic             r_sprite_on, r_collision;
    logic [10:0]      w_y_end;
    logic             w_line_active, w_start_pos, w_drawing, w_pix;

    // 11-bit compares so a sprite near the bottom clips instead of wrapping
    assign w_y_end       = {1'b0, r_y} + {3'b000, r_h};
    assign w_line_active = (vpos >= r_y) && ({1'b0, vpos} < w_y_end);
    assign w_start_pos   = ({1'b0, hpos} == (11'(LINE_START) + {1'b0, r_x}));
    assign w_sub_last    = (r_size == 2'b00) ? LAST_1X :
                           (r_size == 2'b01) ? LAST_2X : LAST_4X;
    assign w_bit_end     = r_refl ? 3'd7 : 3'd0;

    // Shadow registers accept bus writes at any time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gfx_sh  <= '0;
            r_x_sh    <= '0;
            r_refl_sh <= 1'b0;
            r_size_sh <= '0;
            r_y_sh    <= '0;
            r_h_sh    <= '0;
            r_col_sh  <= '0;
        end else if (write_enable) begin
            case (address)
                3'd0: r_gfx_sh <= data_in;
                3'd1: r_x_sh[7:0] <= data_in;
                3'd2: begin
                    r_x_sh[9:8] <= data_in[1:0];
                    r_refl_sh   <= data_in[4];
                    r_size_sh   <= data_in[6:5];
                end
                3'd3: r_y_sh[7:0] <= data_in;
                3'd4: r_y_sh[9:8] <= data_in[1:0];
                3'd5: r_h_sh <= data_in;
                3'd6: r_col_sh <= data_in;
                default: ;
            endcase
        end
    end

    // Active registers follow the shadows only at the line latch point
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gfx  <= '0;
            r_x    <= '0;
            r_refl <= 1'b0;
            r_size <= '0;
            r_y    <= '0;
            r_h    <= '0;
            r_col  <= '0;
        end else if (hpos == 10'd0) begin
            r_gfx  <= r_gfx_sh;
            r_x    <= r_x_sh;
            r_refl <= r_refl_sh;
            r_size <= r_size_sh;
            r_y    <= r_y_sh;
            r_h    <= r_h_sh;
            r_col  <= r_col_sh;
        end
    end

    // Next state and current bit; the start cycle already emits the first pixel
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_sub_nxt   = r_sub;
        w_bit       = r_bit_idx;
        w_sub       = r_sub;
        w_drawing   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_pos && w_line_active && in_image) begin
                    w_drawing   = 1'b1;
                    w_bit       = r_refl ? 3'd0 : 3'd7;
                    w_sub       = '0;
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (!in_image) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drawing = 1'b1;
                end
            end
            DONE: begin
                if (hpos == 10'd0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_drawing) begin
            if (w_sub == w_sub_last) begin
                w_sub_nxt = '0;
                w_bit_nxt = w_bit;
                if (w_bit == w_bit_end) begin
                    w_state_nxt = DONE;
                end else begin
                    w_bit_nxt = r_refl ? (w_bit + 3'd1) : (w_bit - 3'd1);
                end
            end else begin
                w_sub_nxt = w_sub + SUB_W'(1);
                w_bit_nxt = w_bit;
            end
        end
    end

    assign w_pix = w_drawing && r_gfx[w_bit];

    // FSM state and bit/sub-pixel counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_sub     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_nxt;
            r_sub     <= w_sub_nxt;
        end
    end

    // Registered pixel and sticky collision; a new overlap beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sprite_on <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_sprite_on <= w_pix;
            if (w_pix && is_fg) begin
                r_collision <= 1'b1;
            end else if (write_enable && (address == 3'd7)) begin
                r_collision <= 1'b0;
            end
        end
    end

    assign sprite_on = r_sprite_on;
    assign collision = r_collision;
    assign red       = {r_col[7:5], r_col[7:5], r_col[7:6]};
    assign green     = {r_col[4:2], r_col[4:2], r_col[4:3]};
    assign blue      = {r_col[1:0], r_col[1:0], r_col[1:0], r_col[1:0]};

endmodule

// File: tb/tb_player_sprite.sv
// Bench for player_sprite: drives its own line timing, keeps a byte-level
// register model and derives each line's lit pixels arithmetically.
module tb_player_sprite;

    localparam int H_TOTAL = 800;
    localparam int VIS_BEG = 88;
    localparam int VIS_END = 728;
    localparam int V_VIS   = 16;
    localparam int PU      = 4;
    localparam int V_IDLE  = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [2:0] address;
    logic [7:0] data_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       in_image;
    logic       is_fg;
    logic       sprite_on;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       collision;

    logic [7:0] m_sh  [0:6];
    logic [7:0] m_act [0:6];
    bit         m_coll;
    int         vectors;
    int         miscompares;
    int         lit_cnt;
    int         first_lit;
    int         last_lit;

    player_sprite #(.PIXEL_UNIT(4), .LINE_START(88)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .hpos         (hpos),
        .vpos         (vpos),
        .in_image     (in_image),
        .is_fg        (is_fg),
        .sprite_on    (sprite_on),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    function automatic bit vis(input int h, input int v);
        return (h >= VIS_BEG) && (h < VIS_END) && (v < V_VIS);
    endfunction

    // Opaque pixel expected at (h, v) from the active register bytes
    function automatic bit model_pix(input int h, input int v);
        int x, y, ht, sz, w, start, b;
        bit refl;
        x     = {m_act[2][1:0], m_act[1]};
        y     = {m_act[4][1:0], m_act[3]};
        ht    = m_act[5];
        sz    = m_act[2][6:5];
        refl  = m_act[2][4];
        w     = PU << ((sz > 1) ? 2 : sz);
        start = VIS_BEG + x;
        if (ht == 0 || v < y || v >= y + ht) return 1'b0;
        if (!vis(start, v) || h < start || !vis(h, v)) return 1'b0;
        if (h - start >= 8 * w) return 1'b0;
        b = (h - start) / w;
        return m_act[0][refl ? b : 7 - b];
    endfunction

    function automatic logic [23:0] model_rgb(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: drive at negedge, update model, sample 1 ns after posedge
    task automatic step(input int h, input int v, input bit we, input int addr,
                        input logic [7:0] d, input bit fg);
        bit pix;
        logic [23:0] exp_rgb;
        @(negedge clk);
        hpos         = 10'(h);
        vpos         = 10'(v);
        in_image     = vis(h, v);
        is_fg        = fg;
        write_enable = we;
        address      = 3'(addr);
        data_in      = d;
        pix = model_pix(h, v);
        if (pix && fg) m_coll = 1'b1;
        else if (we && addr == 7) m_coll = 1'b0;
        if (h == 0) for (int i = 0; i < 7; i++) m_act[i] = m_sh[i];
        if (we && addr < 7) m_sh[addr] = d;
        exp_rgb = model_rgb(m_act[6]);
        @(posedge clk);
        #1;
        vectors++;
        assert (sprite_on === pix) else begin
            miscompares++;
            $error("FAIL sprite_on v=%0d h=%0d got %b exp %b", v, h, sprite_on, pix);
        end
        vectors++;
        assert (collision === m_coll) else begin
            miscompares++;
            $error("FAIL collision v=%0d h=%0d got %b exp %b", v, h, collision, m_coll);
        end
        vectors++;
        assert ({red, green, blue} === exp_rgb) else begin
            miscompares++;
            $error("FAIL colour v=%0d h=%0d got %h exp %h", v, h, {red, green, blue}, exp_rgb);
        end
        if (sprite_on === 1'b1) begin
            lit_cnt++;
            if (first_lit < 0) first_lit = h + 1;
            last_lit = h + 1;
        end
        write_enable = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [7:0] d);
        step(H_TOTAL - 1, V_IDLE, 1'b1, addr, d, 1'b0);
    endtask

    task automatic run_line(input int v, input int wr_h, input int wr_a,
                            input logic [7:0] wr_d, input int fg_h, input bit fg_rand);
        bit fg;
        lit_cnt = 0; first_lit = -1; last_lit = -1;
        for (int h = 0; h < H_TOTAL; h++) begin
            fg = fg_rand ? ($urandom_range(0, 5) == 0) : (h == fg_h);
            step(h, v, (h == wr_h), wr_a, wr_d, fg);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; m_coll = 1'b0;
        lit_cnt = 0; first_lit = -1; last_lit = -1;
        for (int i = 0; i < 7; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        reset = 1'b0; write_enable = 1'b0; address = '0; data_in = '0;
        hpos = '0; vpos = '0; in_image = 1'b0; is_fg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sprite_on", sprite_on, 0);
        chk("rst_collision", collision, 0);
        chk("rst_rgb", {red, green, blue}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic draw 0x81 at x=0, y=10, height 2, 1x
        wr(0, 8'h81); wr(1, 8'h00); wr(2, 8'h00); wr(3, 8'd10);
        wr(4, 8'h00); wr(5, 8'd2); wr(6, 8'hE3);
        run_line(9, -1, 0, 8'h00, -1, 1'b0);
        chk("basic_l9_cnt", lit_cnt, 0);
        run_line(10, -1, 0, 8'h00, -1, 1'b0);
        chk("basic_l10_cnt", lit_cnt, 8);
        chk("basic_l10_first", first_lit, 89);
        chk("basic_l10_last", last_lit, 120);
        run_line(11, -1, 0, 8'h00, -1, 1'b0);
        chk("basic_l11_cnt", lit_cnt, 8);
        run_line(12, -1, 0, 8'h00, -1, 1'b0);
        chk("basic_l12_cnt", lit_cnt, 0);

        // Reflect with 2x stretch, then the same without reflect
        wr(0, 8'hF0); wr(2, 8'h30);
        run_line(10, -1, 0, 8'h00, -1, 1'b0);
        chk("refl_first", first_lit, 121);
        chk("refl_cnt", lit_cnt, 32);
        wr(2, 8'h20);
        run_line(11, -1, 0, 8'h00, -1, 1'b0);
        chk("norefl_first", first_lit, 89);
        chk("norefl_cnt", lit_cnt, 32);

        // Mid-line graphic write must wait for the next line
        wr(0, 8'h00); wr(2, 8'h00);
        run_line(10, 200, 0, 8'hFF, -1, 1'b0);
        chk("midwr_l10_cnt", lit_cnt, 0);
        run_line(11, -1, 0, 8'h00, -1, 1'b0);
        chk("midwr_l11_cnt", lit_cnt, 32);
        chk("midwr_l11_first", first_lit, 89);

        // Right-edge clip at x=630, 4x
        wr(1, 8'h76); wr(2, 8'h42);
        run_line(10, -1, 0, 8'h00, -1, 1'b0);
        chk("clip_l10_cnt", lit_cnt, 10);
        chk("clip_l10_first", first_lit, 719);
        run_line(11, -1, 0, 8'h00, -1, 1'b0);
        chk("clip_l11_first", first_lit, 719);
        chk("clip_l11_cnt", lit_cnt, 10);

        // Collision: single-pixel overlap, sticky, clear, set-beats-clear
        wr(0, 8'h81); wr(1, 8'h00); wr(2, 8'h00);
        run_line(10, -1, 0, 8'h00, 90, 1'b0);
        chk("coll_set", collision, 1);
        run_line(11, -1, 0, 8'h00, -1, 1'b0);
        chk("coll_sticky", collision, 1);
        wr(7, 8'h00);
        chk("coll_clear", collision, 0);
        run_line(10, 90, 7, 8'h00, 90, 1'b0);
        chk("coll_set_wins", collision, 1);

        // Async reset in the middle of a lit run
        wr(0, 8'hFF);
        lit_cnt = 0; first_lit = -1; last_lit = -1;
        for (int h = 0; h <= 100; h++) step(h, 10, 1'b0, 0, 8'h00, 1'b0);
        chk("pre_rst_on", sprite_on, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_sprite_on", sprite_on, 0);
        chk("arst_collision", collision, 0);
        chk("arst_rgb", {red, green, blue}, 0);
        m_coll = 1'b0;
        for (int i = 0; i < 7; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        @(negedge clk);
        reset = 1'b1;
        for (int h = 101; h < H_TOTAL; h++) step(h, 10, 1'b0, 0, 8'h00, 1'b0);
        wr(0, 8'hFF); wr(3, 8'd10); wr(6, 8'hE3);
        run_line(10, -1, 0, 8'h00, -1, 1'b1);
        chk("h0_l10_cnt", lit_cnt, 0);
        run_line(11, -1, 0, 8'h00, -1, 1'b1);
        chk("h0_l11_cnt", lit_cnt, 0);

        // Randomized configurations against the line model
        for (int it = 0; it < 14; it++) begin
            int x, y, ht, v;
            logic [7:0] b2;
            x  = $urandom_range(0, 700);
            y  = $urandom_range(0, 13);
            ht = $urandom_range(0, 4);
            b2 = {1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'b00, 2'(x >> 8)};
            wr(0, 8'($urandom)); wr(1, 8'(x)); wr(2, b2); wr(3, 8'(y));
            wr(4, 8'h00); wr(5, 8'(ht)); wr(6, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                v = y - 1 + $urandom_range(0, ht + 1);
                if (v < 0) v = 0;
                run_line(v, $urandom_range(0, H_TOTAL - 1), $urandom_range(0, 7),
                         8'($urandom), -1, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
